// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave between up to four VProc bus masters.
// Transactions are serialised IDLE -> WAIT_ACK -> RESP -> DONE, with an ack-timeout watchdog.
module vproc_bus_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS-1:0]    m_rd,
    output logic [32*NUM_MASTERS-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]    m_wrack,
    output logic [NUM_MASTERS-1:0]    m_rdack,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic                      s_we,
    output logic                      s_rd,
    input  logic [31:0]               s_rdata,
    input  logic                      s_ack,
    output logic [1:0]                grant,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RESP     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             grant_reg, grant_next;
    logic [1:0]             last_grant_reg, last_grant_next;
    logic [31:0]            s_addr_reg, s_addr_next;
    logic [31:0]            s_wdata_reg, s_wdata_next;
    logic                   s_we_reg, s_we_next;
    logic                   s_rd_reg, s_rd_next;
    logic [WDW-1:0]         wdog_reg, wdog_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic [NUM_MASTERS-1:0] wrack_reg, wrack_next;
    logic [NUM_MASTERS-1:0] rdack_reg, rdack_next;

    logic [31:0]            addr_arr  [NUM_MASTERS];
    logic [31:0]            wdata_arr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] req;
    logic [1:0]             sel;
    logic [1:0]             sel_hi;
    logic [1:0]             sel_lo;
    logic                   found_hi;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic                   sel_we;
    logic                   wdog_expire;
    logic                   complete;
    logic                   capture;
    logic [31:0]            capture_data;

    assign req = m_we | m_rd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            logic [31:0] rdata_reg;

            assign addr_arr[gi]          = m_addr[32*gi +: 32];
            assign wdata_arr[gi]         = m_wdata[32*gi +: 32];
            assign m_rdata[32*gi +: 32]  = rdata_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (capture && (grant_reg == 2'(gi))) begin
                    rdata_reg <= capture_data;
                end
            end
        end
    endgenerate

    // Expiry is flagged in the last counted cycle, so WAIT_ACK lasts exactly TIMEOUT_CYCLES cycles.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            assign wdog_expire = (wdog_reg == WDW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            assign wdog_expire = 1'b0;
        end
    endgenerate

    // A real s_ack always wins over a coincident expiry, so its data is kept.
    assign complete     = (state_reg == WAIT_ACK) && (s_ack || wdog_expire);
    assign capture      = complete && s_rd_reg;
    assign capture_data = s_ack ? s_rdata : TIMEOUT_RDATA;

    // Round robin: lowest requester above last_grant, else lowest requester overall.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_lo = 2'(i);
                if (2'(i) > last_grant_reg) begin
                    sel_hi   = 2'(i);
                    found_hi = 1'b1;
                end
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel == 2'(i)) begin
                sel_addr  = addr_arr[i];
                sel_wdata = wdata_arr[i];
                sel_we    = m_we[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            last_grant_reg  <= 2'(NUM_MASTERS - 1);
            s_addr_reg      <= '0;
            s_wdata_reg     <= '0;
            s_we_reg        <= 1'b0;
            s_rd_reg        <= 1'b0;
            wdog_reg        <= '0;
            timeout_err_reg <= 1'b0;
            wrack_reg       <= '0;
            rdack_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            s_addr_reg      <= s_addr_next;
            s_wdata_reg     <= s_wdata_next;
            s_we_reg        <= s_we_next;
            s_rd_reg        <= s_rd_next;
            wdog_reg        <= wdog_next;
            timeout_err_reg <= timeout_err_next;
            wrack_reg       <= wrack_next;
            rdack_reg       <= rdack_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        s_addr_next      = s_addr_reg;
        s_wdata_next     = s_wdata_reg;
        s_we_next        = s_we_reg;
        s_rd_next        = s_rd_reg;
        wdog_next        = wdog_reg;
        timeout_err_next = timeout_err_reg;
        wrack_next       = '0;
        rdack_next       = '0;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next      = WAIT_ACK;
                    grant_next      = sel;
                    last_grant_next = sel;
                    s_addr_next     = sel_addr;
                    s_wdata_next    = sel_wdata;
                    // A write wins; any read held alongside it stays pending for a later window.
                    s_we_next       = sel_we;
                    s_rd_next       = ~sel_we;
                    wdog_next       = '0;
                end
            end
            WAIT_ACK: begin
                wdog_next = wdog_reg + WDW'(1);
                if (complete) begin
                    state_next = RESP;
                    s_we_next  = 1'b0;
                    s_rd_next  = 1'b0;
                    if (!s_ack) begin
                        timeout_err_next = 1'b1;
                    end
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (grant_reg == 2'(i)) begin
                            wrack_next[i] = s_we_reg;
                            rdack_next[i] = s_rd_reg;
                        end
                    end
                end
            end
            RESP: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m_wrack     = wrack_reg;
    assign m_rdack     = rdack_reg;
    assign s_addr      = s_addr_reg;
    assign s_wdata     = s_wdata_reg;
    assign s_we        = s_we_reg;
    assign s_rd        = s_rd_reg;
    assign grant       = grant_reg;
    assign busy        = (state_reg != IDLE);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Scoreboard bench for vproc_bus_arbiter: directed transactions push expected acks,
// an independent monitor pops and compares on every master acknowledge.
module tb_vproc_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [32*N-1:0] m_addr;
    logic [32*N-1:0] m_wdata;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_rd;
    logic [32*N-1:0] m_rdata;
    logic [N-1:0]    m_wrack;
    logic [N-1:0]    m_rdack;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic            s_we;
    logic            s_rd;
    logic [31:0]     s_rdata;
    logic            s_ack = 1'b0;
    logic [1:0]      grant;
    logic            busy;
    logic            timeout_err;

    typedef struct {
        int          master;
        bit          is_wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   tests       = 0;
    int   fails       = 0;
    int   cyc         = 0;
    int   slave_delay = 0;
    bit   slave_mute  = 1'b0;
    int   wait_cnt    = 0;
    int   ack_cyc     = 0;
    int   strobe_cyc  = 0;

    vproc_bus_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_RDATA  (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_we        (m_we),
        .m_rd        (m_rd),
        .m_rdata     (m_rdata),
        .m_wrack     (m_wrack),
        .m_rdack     (m_rdack),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_we        (s_we),
        .s_rd        (s_rd),
        .s_rdata     (s_rdata),
        .s_ack       (s_ack),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input int master, input bit is_wr, input logic [31:0] rdata);
        exp_t e;
        e.master = master;
        e.is_wr  = is_wr;
        e.rdata  = rdata;
        sb.push_back(e);
    endtask

    task automatic req(input int i, input bit we, input bit rd, input logic [31:0] a, input logic [31:0] d);
        m_addr[32*i +: 32]  = a;
        m_wdata[32*i +: 32] = d;
        m_we[i]             = we;
        m_rd[i]             = rd;
    endtask

    // Counts acks on negedges; optionally drops each acked request like a real master.
    task automatic wait_acks(input string name, input int n, input bit drop);
        int seen;
        int budget;
        seen   = 0;
        budget = 0;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (m_wrack != '0 || m_rdack != '0) begin
                seen++;
                ack_cyc = cyc;
                if (drop) begin
                    m_we = m_we & ~m_wrack;
                    m_rd = m_rd & ~m_rdack;
                end
            end
        end
        check(name, 64'(seen), 64'(n));
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (busy && budget < 50);
        check(name, {63'b0, busy}, 64'd0);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_strobe(input string name);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(s_we || s_rd) && budget < 20);
        strobe_cyc = cyc;
        check(name, {63'b0, (s_we || s_rd)}, 64'd1);
    endtask

    // Slave: acks slave_delay cycles after the strobe appears, unless muted.
    always @(negedge clk) begin
        if ((s_we || s_rd) && !slave_mute && !rst) begin
            s_ack = (wait_cnt == slave_delay);
            wait_cnt++;
        end else begin
            s_ack    = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [N-1:0] oh;
        if (m_wrack != '0 || m_rdack != '0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: wrack=%b rdack=%b, required no ack", m_wrack, m_rdack);
            end else begin
                e  = sb.pop_front();
                oh = N'(1) << e.master;
                check("ack_wrack", 64'(m_wrack), e.is_wr ? 64'(oh) : 64'd0);
                check("ack_rdack", 64'(m_rdack), e.is_wr ? 64'd0 : 64'(oh));
                check("ack_grant", 64'(grant), 64'(e.master));
                if (!e.is_wr) begin
                    check("ack_rdata", 64'(m_rdata[32*e.master +: 32]), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        m_addr  = '0;
        m_wdata = '0;
        m_we    = '0;
        m_rd    = '0;
        s_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_we", {63'b0, s_we}, 64'd0);
        check("rst_s_rd", {63'b0, s_rd}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_timeout_err", {63'b0, timeout_err}, 64'd0);
        check("rst_acks", 64'({m_wrack, m_rdack}), 64'd0);
        check("rst_m_rdata", 64'(m_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write, slave acks in the strobe cycle
        slave_delay = 0;
        expect_ack(0, 1'b1, 32'h0);
        req(0, 1'b1, 1'b0, 32'h10, 32'h1);
        @(negedge clk);
        check("t1_s_we", {63'b0, s_we}, 64'd1);
        check("t1_s_rd", {63'b0, s_rd}, 64'd0);
        check("t1_s_addr", 64'(s_addr), 64'h10);
        check("t1_s_wdata", 64'(s_wdata), 64'h1);
        @(negedge clk);
        check("t1_s_we_1cycle", {63'b0, s_we}, 64'd0);
        check("t1_wrack_m_plus_1", 64'(m_wrack), 64'b01);
        m_we[0] = 1'b0;
        @(negedge clk);
        check("t1_busy_done", {63'b0, busy}, 64'd1);
        @(negedge clk);
        check("t1_busy_idle", {63'b0, busy}, 64'd0);

        // Read with 3-cycle slave wait on master 1
        slave_delay = 3;
        s_rdata     = 32'h00002710;
        expect_ack(1, 1'b0, 32'h00002710);
        req(1, 1'b0, 1'b1, 32'h4, 32'h0);
        wait_acks("t2_acks", 1, 1'b1);
        wait_idle("t2_idle");
        check("t2_m_rdata0_unchanged", 64'(m_rdata[31:0]), 64'd0);

        // Fairness: both masters hold reads for six transactions
        slave_delay = 0;
        s_rdata     = 32'hA5A50001;
        for (int k = 0; k < 6; k++) expect_ack(k % 2, 1'b0, 32'hA5A50001);
        req(0, 1'b0, 1'b1, 32'h40, 32'h0);
        req(1, 1'b0, 1'b1, 32'h44, 32'h0);
        wait_acks("t3_acks", 6, 1'b0);
        m_rd = '0;
        wait_idle("t3_idle");

        // Simultaneous we and rd on master 0: write first, read in the next window
        s_rdata = 32'h00001234;
        expect_ack(0, 1'b1, 32'h0);
        expect_ack(0, 1'b0, 32'h00001234);
        req(0, 1'b1, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        check("t4_first_s_we", {63'b0, s_we}, 64'd1);
        check("t4_first_s_rd", {63'b0, s_rd}, 64'd0);
        wait_acks("t4_acks", 2, 1'b1);
        wait_idle("t4_idle");
        check("t4_m_rdata1_unchanged", 64'(m_rdata[63:32]), 64'hA5A50001);

        // Watchdog: slave never acks a read
        slave_mute = 1'b1;
        check("t5_err_before", {63'b0, timeout_err}, 64'd0);
        expect_ack(1, 1'b0, 32'hDEADBEEF);
        req(1, 1'b0, 1'b1, 32'h8, 32'h0);
        wait_strobe("t5_strobe");
        wait_acks("t5_acks", 1, 1'b1);
        check("t5_ack_latency", 64'(ack_cyc - strobe_cyc), 64'(TO));
        wait_idle("t5_idle");
        repeat (5) @(negedge clk);
        check("t5_err_sticky", {63'b0, timeout_err}, 64'd1);

        // Reset in WAIT_ACK, master 0 holding the bus; afterwards master 0 must win first
        req(0, 1'b0, 1'b1, 32'h30, 32'h0);
        wait_strobe("t6_strobe");
        check("t6_grant_before", 64'(grant), 64'd0);
        #1 rst = 1'b1;
        req(1, 1'b0, 1'b1, 32'h34, 32'h0);
        #1;
        check("t6_s_rd_async", {63'b0, s_rd}, 64'd0);
        check("t6_busy_async", {63'b0, busy}, 64'd0);
        check("t6_err_cleared", {63'b0, timeout_err}, 64'd0);
        repeat (2) @(negedge clk);
        slave_mute = 1'b0;
        s_rdata    = 32'hCAFE0000;
        expect_ack(0, 1'b0, 32'hCAFE0000);
        expect_ack(1, 1'b0, 32'hCAFE0000);
        rst = 1'b0;
        wait_acks("t6_acks", 2, 1'b1);
        wait_idle("t6_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vproc_bus_arbiter.md
Name: vproc_bus_arbiter

Overview:
- Round-robin arbiter that shares one memory-mapped slave between up to four VProc bus masters, e.g. several VProc nodes sharing a single simulation control register block.
- Serialises transactions, one at a time, and returns per-master acknowledges and read data.
- Includes an ack-timeout watchdog so that a missing slave response cannot hang the simulation.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; legal range 1–4.
- TIMEOUT_CYCLES, 1024, number of cycles in WAIT_ACK without s_ack before the arbiter forces completion; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEADBEEF, read data returned on a timed-out read.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- m_addr  input  32*NUM_MASTERS  per-master address; master i occupies bits [32i+31:32i].
- m_wdata  input  32*NUM_MASTERS  per-master write data.
- m_we  input  NUM_MASTERS  write request, held until acked.
- m_rd  input  NUM_MASTERS  read request, held until acked.
- m_rdata  output  32*NUM_MASTERS  per-master read data, registered.
- m_wrack  output  NUM_MASTERS  one-cycle write acknowledge.
- m_rdack  output  NUM_MASTERS  one-cycle read acknowledge.
- s_addr  output  32  slave address.
- s_wdata  output  32  slave write data.
- s_we  output  1  slave write strobe.
- s_rd  output  1  slave read strobe.
- s_rdata  input  32  slave read data, valid when s_ack is high.
- s_ack  input  1  slave completion; may be asserted in the same cycle as the strobe.
- grant  output  2  index of the master currently owning the slave.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky flag, set on any watchdog expiry.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = NUM_MASTERS-1, so master 0 wins first. m_rdata is held at 0 until the first read.
- A master is requesting when m_we[i] | m_rd[i] is high.
- States: IDLE → WAIT_ACK → RESP → DONE → IDLE.
- IDLE:
  - If any master is requesting, select the first requester searching upward from last_grant+1, modulo NUM_MASTERS.
  - Register grant, s_addr, s_wdata and s_we/s_rd for that master, update last_grant, and go to WAIT_ACK.
  - The slave strobe asserts the cycle after the request is first seen.
- Write priority: if a master asserts we and rd together, only the write is issued and only wrack is pulsed. Its rd remains pending and is arbitrated again later.
- WAIT_ACK:
  - Strobe and address are held stable.
  - On s_ack: deassert strobes, latch s_rdata into m_rdata[grant] if the transaction is a read, and go to RESP.
  - A watchdog counter increments each cycle in this state. When it reaches TIMEOUT_CYCLES, treat the cycle as s_ack with read data TIMEOUT_RDATA, and set timeout_err.
- RESP: pulse m_wrack[grant] or m_rdack[grant] for exactly one cycle, then go to DONE.
- DONE:
  - One cycle in which all requests are ignored, giving the served master time to drop its request; then return to IDLE.
  - Minimum transaction period, with s_ack in the same cycle as the strobe, is 4 cycles.
- Latency: request first seen at cycle N → strobe at N+1 → s_ack at M ≥ N+1 → master ack at M+1 → IDLE at M+3.
- Requests are sampled only in IDLE. Changes to other masters' signals while busy have no effect until the next IDLE.
- s_ack outside WAIT_ACK is ignored.
- The watchdog counter clears on entry to WAIT_ACK. Its width is clog2(TIMEOUT_CYCLES+1).
- timeout_err clears only on rst.
- Asynchronous reset mid-transaction: return immediately to IDLE, drop strobes and acks, and emit no ack for the aborted transaction.
- NUM_MASTERS=1: always grant 0; the state machine is unchanged.
- For NUM_MASTERS < 4, the unused upper bits of grant are 0.

Test Plan:
- Single write: master 0 writes addr 32'h10, data 32'h1, slave acks in the strobe cycle → s_we is high for 1 cycle with s_addr=32'h10, m_wrack[0] pulses at M+1, busy is low 3 cycles after s_ack.
- Read with 3-cycle slave wait: master 1 reads addr 32'h4, s_rdata=32'h00002710 → m_rdack[1] pulses once and m_rdata[1]=32'h00002710; m_rdata[0] is unchanged.
- Fairness: masters 0 and 1 both hold continuous reads for 6 transactions → grant sequence 0,1,0,1,0,1 and no master acked twice in a row.
- Simultaneous we and rd on master 0 → write issued first with only wrack; the read follows in the next arbitration window with rdack.
- Timeout: TIMEOUT_CYCLES=8, slave never acks a read → m_rdack pulses 8 cycles after the strobe with m_rdata=32'hDEADBEEF, and timeout_err stays 1 until rst.
- rst asserted in WAIT_ACK → strobes drop asynchronously, no ack is pulsed, and after release master 0 wins first.
